// File: rtl/ahb_wait_mem_slave.sv
// AHB-Lite word-organised memory slave with configurable NONSEQ/SEQ wait states
// and the two-cycle ERROR response for out-of-range, oversize or misaligned transfers.
module ahb_wait_mem_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned WAIT_NSEQ  = 2,
    parameter int unsigned WAIT_SEQ   = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [31:0]           hwdata,
    input  logic                  hreadyin,
    output logic [31:0]           hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    logic [31:0]      mem [DEPTH];
    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             wr_pend;
    logic             rd_pend;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [3:0]       wr_be;

    logic             accept_c;
    logic             illegal_c;
    logic             commit_c;
    logic [3:0]       be_c;
    logic [CNT_W-1:0] nwait_c;
    logic [IDX_W-1:0] idx_c;
    logic [31:0]      merged_c;
    logic [31:0]      rd_word_c;

    // Address-phase decode, pending-write merge and read-after-write bypass
    always_comb begin
        accept_c  = hsel && hreadyin && htrans[1] && (state == ST_IDLE || state == ST_ERR2);
        idx_c     = haddr[IDX_W+1:2];
        nwait_c   = htrans[0] ? CNT_W'(WAIT_SEQ) : CNT_W'(WAIT_NSEQ);
        be_c      = 4'b0000;
        illegal_c = 1'b0;
        case (hsize)
            3'd0: be_c = 4'b0001 << haddr[1:0];
            3'd1: begin
                be_c      = haddr[1] ? 4'b1100 : 4'b0011;
                illegal_c = haddr[0];
            end
            3'd2: begin
                be_c      = 4'b1111;
                illegal_c = |haddr[1:0];
            end
            default: illegal_c = 1'b1;
        endcase
        if (haddr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH)) begin
            illegal_c = 1'b1;
        end
        commit_c = wr_pend && (state == ST_IDLE);
        for (int b = 0; b < 4; b++) begin
            merged_c[8*b +: 8] = wr_be[b] ? hwdata[8*b +: 8] : mem[wr_idx][8*b +: 8];
        end
        rd_word_c = (commit_c && (wr_idx == idx_c)) ? merged_c : mem[idx_c];
    end

    // Storage is never reset; a write lands in its completing data-phase cycle
    always_ff @(posedge hclk) begin
        if (commit_c) begin
            mem[wr_idx] <= merged_c;
        end
    end

    // Response FSM with registered bus outputs
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= 32'h0;
            wait_cnt  <= '0;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            wr_be     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    state     <= ST_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    wr_pend   <= 1'b0;
                    rd_pend   <= 1'b0;
                    if (accept_c) begin
                        if (illegal_c) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                            if (!hwrite) hrdata <= 32'h0;
                        end else begin
                            wr_pend <= hwrite;
                            wr_idx  <= idx_c;
                            wr_be   <= be_c;
                            rd_idx  <= idx_c;
                            if (nwait_c == '0) begin
                                if (!hwrite) hrdata <= rd_word_c;
                            end else begin
                                state     <= ST_WAIT;
                                hreadyout <= 1'b0;
                                wait_cnt  <= nwait_c;
                                rd_pend   <= !hwrite;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == CNT_W'(1)) begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                        if (rd_pend) hrdata <= mem[rd_idx];
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_wait_mem_slave.sv
// Bench for ahb_wait_mem_slave: transaction-level bus model with expected
// response sequences and a byte-lane memory model, directed cases then random traffic.
module tb_ahb_wait_mem_slave;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned WN    = 2;
    localparam int unsigned WS    = 0;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          hsel = 1'b0;
    logic [AW-1:0] haddr = '0;
    logic [1:0]    htrans = 2'b00;
    logic          hwrite = 1'b0;
    logic [2:0]    hsize = 3'd0;
    logic [31:0]   hwdata = '0;
    logic          hreadyin;
    logic [31:0]   hrdata;
    logic          hreadyout;
    logic          hresp;

    assign hreadyin = hreadyout;

    ahb_wait_mem_slave #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_NSEQ(WN), .WAIT_SEQ(WS)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    localparam txn_t IDLE_T = '{sel: 1'b0, trans: 2'b00, wr: 1'b0, size: 3'd0, addr: 32'h0, wdata: 32'h0};

    logic [31:0] mmem   [DEPTH];
    logic [3:0]  mknown [DEPTH];
    txn_t        cur;
    txn_t        pend;
    int          k;
    int          total;
    int          bad;
    int          data_cycles;
    bit          accepted;
    logic [31:0] last_rd;
    logic [31:0] rd_q[$];

    function automatic bit is_access(txn_t t);
        return t.sel && t.trans[1];
    endfunction

    function automatic bit is_illegal(txn_t t);
        return ((t.addr >> 2) >= DEPTH) || (t.size > 3'd2) ||
               (t.size == 3'd1 && t.addr[0]) || (t.size == 3'd2 && t.addr[1:0] != 2'b00);
    endfunction

    // Data-phase length in cycles: non-access 1, error 2, legal N+1
    function automatic int phase_len(txn_t t);
        if (!is_access(t)) return 1;
        if (is_illegal(t)) return 2;
        return (t.trans[0] ? int'(WS) : int'(WN)) + 1;
    endfunction

    function automatic logic [3:0] lanes(txn_t t);
        logic [3:0] l;
        int base;
        int nb;
        base = int'(t.addr[1:0]);
        nb   = 1 << int'(t.size);
        for (int b = 0; b < 4; b++) l[b] = (b >= base) && (b < base + nb);
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: check outputs for the current data phase, then drive the next address phase
    task automatic cycle();
        int   len;
        bit   done;
        int   idx;
        logic [3:0] l;
        @(negedge hclk);
        len  = phase_len(cur);
        done = (k == len - 1);
        chk("hreadyout", 32'(hreadyout), 32'(done));
        chk("hresp", 32'(hresp), 32'(is_access(cur) && is_illegal(cur)));
        if (is_access(cur)) data_cycles++;
        if (done && is_access(cur)) begin
            idx = int'(cur.addr >> 2);
            if (is_illegal(cur)) begin
                if (!cur.wr) chk("err_rdata", hrdata, 32'h0);
            end else if (cur.wr) begin
                l = lanes(cur);
                for (int b = 0; b < 4; b++) begin
                    if (l[b]) begin
                        mmem[idx][8*b +: 8] = cur.wdata[8*b +: 8];
                        mknown[idx][b] = 1'b1;
                    end
                end
            end else begin
                if (mknown[idx] == 4'hf) chk("rdata", hrdata, mmem[idx]);
                last_rd = hrdata;
                rd_q.push_back(hrdata);
            end
        end
        hsel   = pend.sel;
        htrans = pend.trans;
        hwrite = pend.wr;
        hsize  = pend.size;
        haddr  = pend.addr;
        hwdata = cur.wdata;
        accepted = done;
        if (done) begin
            cur = pend;
            k   = 0;
        end else begin
            k++;
        end
    endtask

    task automatic issue(input txn_t t);
        pend = t;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
        pend = IDLE_T;
    endtask

    function automatic txn_t mk(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.sel = 1'b1; t.trans = tr; t.wr = wr; t.size = sz; t.addr = a; t.wdata = d;
        return t;
    endfunction

    initial begin
        int   dc;
        txn_t t;
        int   r;
        total = 0; bad = 0; data_cycles = 0; k = 0;
        cur = IDLE_T; pend = IDLE_T; last_rd = '0;
        for (int i = 0; i < DEPTH; i++) mknown[i] = 4'h0;

        @(negedge hclk);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
        hresetn = 1'b1;

        // Word write then NONSEQ read with two wait states
        issue(mk(2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
        issue(IDLE_T);
        dc = data_cycles;
        issue(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
        issue(IDLE_T);
        chk("nseq_read_cycles", 32'(data_cycles - dc), 32'd3);
        chk("read_deadbeef", last_rd, 32'hDEADBEEF);

        // Zero-wait SEQ byte write immediately followed by a read of the same word
        issue(mk(2'b11, 1'b1, 3'd0, 32'h11, 32'h0000AB00));
        issue(mk(2'b11, 1'b0, 3'd2, 32'h10, 32'h0));
        issue(IDLE_T);
        chk("byte_merge_raw", last_rd, 32'hDEADABEF);
        issue(mk(2'b11, 1'b1, 3'd2, 32'h10, 32'h12345678));
        issue(mk(2'b11, 1'b0, 3'd2, 32'h10, 32'h0));
        issue(IDLE_T);
        chk("word_raw", last_rd, 32'h12345678);

        // INCR4 write burst then read-back burst
        dc = data_cycles;
        for (int i = 0; i < 4; i++)
            issue(mk(i == 0 ? 2'b10 : 2'b11, 1'b1, 3'd2, 32'h20 + 32'(4 * i), 32'(i + 1)));
        issue(IDLE_T);
        chk("burst_cycles", 32'(data_cycles - dc), 32'd6);
        rd_q.delete();
        for (int i = 0; i < 4; i++)
            issue(mk(i == 0 ? 2'b10 : 2'b11, 1'b0, 3'd2, 32'h20 + 32'(4 * i), 32'h0));
        issue(IDLE_T);
        chk("burst_rd_count", 32'(rd_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++) chk("burst_rd", rd_q[i], 32'(i + 1));

        // Out-of-range read and misaligned word write both error, memory untouched
        dc = data_cycles;
        issue(mk(2'b10, 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0));
        issue(mk(2'b10, 1'b1, 3'd2, 32'h12, 32'hFFFFFFFF));
        issue(IDLE_T);
        chk("err_cycles", 32'(data_cycles - dc), 32'd4);
        chk("err_read_zero", hrdata, 32'h0);
        issue(mk(2'b11, 1'b0, 3'd2, 32'h10, 32'h0));
        issue(IDLE_T);
        chk("after_err_read", last_rd, 32'h12345678);

        // Reset asserted during the first wait cycle of a NONSEQ read
        issue(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
        @(negedge hclk);
        hresetn = 1'b0;
        #1;
        chk("wait_rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("wait_rst_hresp", 32'(hresp), 32'd0);
        chk("wait_rst_hrdata", hrdata, 32'h0);
        cur = IDLE_T; k = 0;
        hsel = 1'b0; htrans = 2'b00;
        #3 hresetn = 1'b1;
        issue(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
        issue(IDLE_T);
        chk("post_rst_read", last_rd, 32'h12345678);

        // Fill every word, then random traffic
        for (int i = 0; i < DEPTH; i++)
            issue(mk(2'b10, 1'b1, 3'd2, 32'(4 * i), $urandom));
        for (int n = 0; n < 500; n++) begin
            t.sel = ($urandom_range(0, 99) < 93);
            r = $urandom_range(0, 9);
            t.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
            t.wr    = 1'($urandom_range(0, 1));
            t.size  = ($urandom_range(0, 11) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
            t.addr  = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 9) < 8 && t.size <= 3'd2) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
            r = $urandom_range(0, 19);
            if (r == 0) t.addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
            else if (r == 1) t.addr = t.addr | 32'h8000_0000;
            t.wdata = $urandom;
            issue(t);
        end
        issue(IDLE_T);
        issue(IDLE_T);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
